// File: rtl/list_pkg.sv
// Shared linked-list memory format: node layout constants and the
// list builder state encoding.
package list_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACCEPT  = 3'd1,
    ST_WR_VAL  = 3'd2,
    ST_WR_NEXT = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Node k of a list sits at head + NODE_WORDS*k; value first, link second.
  localparam int VAL_OFS    = 0;
  localparam int NEXT_OFS   = 1;
  localparam int NODE_WORDS = 2;
  localparam int NULL_PTR   = 0;

endpackage

// File: rtl/list_builder_fsm.sv
// Control FSM of the list builder: state register with Moore outputs
// registered alongside the state, so they always match the current state.
//
//   state      | meaning
//   -----------+-----------------------------------------------
//   ST_IDLE    | waiting for start; base checked on the start cycle
//   ST_ACCEPT  | in_ready high, waiting for an element handshake
//   ST_WR_VAL  | writing the latched value at ptr
//   ST_WR_NEXT | writing the link word at ptr+1 (next node or null)
//   ST_DONE    | done high; held until start is released
module list_builder_fsm
  import list_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   start,
  input  logic   base_ok,
  input  logic   in_valid,
  input  logic   wr_end,
  output state_t state,
  output logic   done,
  output logic   in_ready,
  output logic   mem_we
);

  state_t state_nx;

  // Next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (start) state_nx = base_ok ? ST_ACCEPT : ST_DONE;
      ST_ACCEPT:  if (in_valid) state_nx = ST_WR_VAL;
      ST_WR_VAL:  state_nx = ST_WR_NEXT;
      ST_WR_NEXT: state_nx = wr_end ? ST_DONE : ST_ACCEPT;
      ST_DONE:    if (!start) state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  // State register and the outputs that belong to the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      done     <= 1'b0;
      in_ready <= 1'b0;
      mem_we   <= 1'b0;
    end else begin
      state    <= state_nx;
      done     <= (state_nx == ST_DONE);
      in_ready <= (state_nx == ST_ACCEPT);
      mem_we   <= (state_nx == ST_WR_VAL) || (state_nx == ST_WR_NEXT);
    end
  end

endmodule

// File: rtl/list_builder.sv
// List builder top: streams elements into memory as a null-terminated
// singly linked list of contiguous two-word nodes starting at base.
module list_builder
  import list_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] count,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata
);

  // Highest legal head address of a following node: 2^AW - 2, so that its
  // link word still fits below the top of the address space.
  localparam logic [AW:0] PTR_LIMIT = {1'b0, {(AW-1){1'b1}}, 1'b0};

  state_t        state;
  logic [AW-1:0] ptr;
  logic [DW-1:0] data_q;
  logic          last_q;
  logic          base_ok;
  logic [AW:0]   ptr_step;
  logic          ovf;
  logic          wr_end;
  logic [AW-1:0] link;

  assign base_ok  = (base != '0) && (base != '1);
  assign ptr_step = {1'b0, ptr} + (AW+1)'(NODE_WORDS);
  assign ovf      = (ptr_step > PTR_LIMIT);
  assign wr_end   = last_q | ovf;
  assign link     = wr_end ? AW'(NULL_PTR) : ptr_step[AW-1:0];

  list_builder_fsm u_fsm (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_ok  (base_ok),
    .in_valid (in_valid),
    .wr_end   (wr_end),
    .state    (state),
    .done     (done),
    .in_ready (in_ready),
    .mem_we   (mem_we)
  );

  // Datapath registers: node pointer, node count, error flag, element latch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr    <= '0;
      count  <= '0;
      err    <= 1'b0;
      data_q <= '0;
      last_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (base_ok) begin
              ptr   <= base;
              count <= '0;
              err   <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_ACCEPT: begin
          if (in_valid) begin
            data_q <= in_data;
            last_q <= in_last;
          end
        end
        ST_WR_NEXT: begin
          count <= count + 1'b1;
          ptr   <= ptr_step[AW-1:0];
          if (!last_q && ovf) err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Write address/data mux; zero outside the two write states.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      ST_WR_VAL: begin
        mem_addr  = ptr + AW'(VAL_OFS);
        mem_wdata = data_q;
      end
      ST_WR_NEXT: begin
        mem_addr  = ptr + AW'(NEXT_OFS);
        mem_wdata = DW'(link);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_list_builder.sv
// Directed bench for list_builder with a write scoreboard.
module tb_list_builder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] base = 8'h00;
  logic       done, err;
  logic [7:0] count;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;

  list_builder #(.DW(8), .AW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .base(base),
    .done(done), .err(err), .count(count),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mw;
  int  passed = 0;
  int  total  = 0;
  int  we_cnt = 0;
  int  m_ptr, m_count;
  bit  m_err, m_stop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic void push_wr(input int a, input int d);
    wr_t w;
    w.a = 8'(a);
    w.d = 8'(d);
    exp_q.push_back(w);
  endfunction

  // Write monitor: every strobe must match the next expected write.
  always @(negedge clk) begin
    if (rst === 1'b1 && mem_we === 1'b1) begin
      we_cnt++;
      check("wr_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        mw = exp_q.pop_front();
        check("wr_addr", mem_addr, mw.a);
        check("wr_data", mem_wdata, mw.d);
      end
    end
    if (rst === 1'b1 && in_ready === 1'b1)
      check("ready_only_accept", {mem_we, done}, 0);
  end

  task automatic begin_run(input logic [7:0] b, input bit hold);
    m_ptr = b; m_count = 0; m_err = 0; m_stop = 0;
    @(negedge clk);
    start = 1'b1; base = b;
    @(negedge clk);
    check("first_ready", in_ready, 1);
    check("start_count_clear", count, 0);
    if (!hold) start = 1'b0;
  endtask

  // Drive one element after gap idle cycles; push its expected writes.
  task automatic send(input logic [7:0] d, input bit l, input int gap);
    int  nx;
    bit  got;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = l;
    push_wr(m_ptr, d);
    nx = m_ptr + 2;
    if (l) begin
      push_wr(m_ptr + 1, 0); m_stop = 1;
    end else if (nx > 254) begin
      push_wr(m_ptr + 1, 0); m_err = 1; m_stop = 1;
    end else begin
      push_wr(m_ptr + 1, nx);
    end
    m_ptr = nx;
    m_count++;
    got = 0;
    for (int t = 0; t < 50; t++) begin
      if (in_ready) begin got = 1; break; end
      @(negedge clk);
    end
    check("hs_timeout", got, 1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while (!done && t < 60) begin @(negedge clk); t++; end
    check({tag, "_done"}, done, 1);
    check({tag, "_count"}, count, 32'(m_count));
    check({tag, "_err"}, err, 32'(m_err));
    check({tag, "_all_writes"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int  w0;
    bit  hs4;

    // Reset values
    #12;
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_count", count, 0);
    check("rst_ready", in_ready, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    @(negedge clk); rst = 1'b1;

    // Three-element list with done latency after the last link write
    begin_run(8'h10, 0);
    send(8'd5, 0, 0);
    send(8'd7, 0, 0);
    send(8'd9, 1, 0);
    check("t1_done_wrval", done, 0);
    @(negedge clk);
    check("t1_done_wrnext", done, 0);
    @(negedge clk);
    check("t1_done_latency", done, 1);
    wait_done("t1");

    // Illegal bases: one cycle to done, no writes, count held
    w0 = we_cnt;
    @(negedge clk); start = 1'b1; base = 8'h00;
    @(negedge clk);
    check("ill00_done", done, 1);
    check("ill00_err", err, 1);
    check("ill00_count_held", count, 3);
    start = 1'b0;
    @(negedge clk);
    check("ill00_idle", done, 0);
    start = 1'b1; base = 8'hFF;
    @(negedge clk);
    check("illFF_done", done, 1);
    check("illFF_err", err, 1);
    start = 1'b0;
    @(negedge clk);
    check("ill_no_writes", we_cnt - w0, 0);

    // Overflow near the top of memory
    begin_run(8'hFA, 0);
    send(8'hA1, 0, 0);
    send(8'hA2, 0, 0);
    send(8'hA3, 0, 0);
    in_valid = 1'b1; in_data = 8'hA4;
    hs4 = 0;
    for (int t = 0; t < 6; t++) begin
      if (in_ready) hs4 = 1;
      @(negedge clk);
    end
    check("ovf_no_4th_hs", hs4, 0);
    in_valid = 1'b0;
    check("ovf_count", count, 3);
    check("ovf_err", err, 1);
    check("ovf_all_writes", exp_q.size(), 0);
    exp_q.delete();

    // Backpressure: same list with idle gaps on in_valid
    begin_run(8'h10, 0);
    send(8'd5, 0, 2);
    send(8'd7, 0, 2);
    send(8'd9, 1, 2);
    wait_done("bp");

    // Start held through done, then restart
    begin_run(8'h20, 1);
    send(8'h55, 1, 0);
    wait_done("hold");
    w0 = we_cnt;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      check("hold_stay_done", done, 1);
    end
    check("hold_no_writes", we_cnt - w0, 0);
    start = 1'b0;
    @(negedge clk);
    check("hold_idle", done, 0);
    check("hold_count_kept", count, 1);
    begin_run(8'h30, 0);
    send(8'h11, 0, 1);
    send(8'h22, 1, 0);
    wait_done("restart");

    // Reset asserted during the value write
    begin_run(8'h40, 0);
    in_valid = 1'b1; in_data = 8'h66; in_last = 1'b0;
    push_wr(8'h40, 8'h66);
    hs4 = 0;
    for (int t = 0; t < 20; t++) begin
      if (in_ready) begin hs4 = 1; break; end
      @(negedge clk);
    end
    check("mr_hs", hs4, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("mr_in_wrval", mem_we, 1);
    #2 rst = 1'b0;
    #1;
    check("mr_async_we", mem_we, 0);
    check("mr_async_addr", mem_addr, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("mr_done", done, 0);
    check("mr_err", err, 0);
    check("mr_count", count, 0);
    check("mr_ready", in_ready, 0);
    check("mr_we", mem_we, 0);
    check("mr_wdata", mem_wdata, 0);
    check("mr_writes", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/list_builder.md
# list_builder

List builder: the writer side of the team's linked-list memory format, i.e. the producer of the lists that the summation controller later traverses. On `start` it accepts a stream of values over a valid/ready input and writes them to memory as a null-terminated singly linked list. Nodes are placed contiguously from a given head address. It sits beside the summation datapath on the same memory write port and uses the same `start`/`done` handshake.

## Interface
- `DW`, default 8: data word width; must be ≥ `AW`.
- `AW`, default 8: memory address width; the pointer value 0 is the null terminator.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  level request; sampled in IDLE and DONE only.
- `base`  in  AW  head-node address; sampled on the start cycle.
- `done`  out  1  high while in DONE.
- `err`  out  1  high in DONE if the list was cut short or `base` was illegal.
- `count`  out  AW  number of nodes written in the current or last run.
- `in_valid`  in  1  input element valid.
- `in_ready`  out  1  element accepted when `in_valid & in_ready`.
- `in_data`  in  DW  element value.
- `in_last`  in  1  marks the final element; qualified by `in_valid`.
- `mem_we`  out  1  single-cycle write strobe; memory commits on the same edge.
- `mem_addr`  out  AW  write address.
- `mem_wdata`  out  DW  write data; pointers are zero-extended to `DW`.

## Operation
- Node layout, two words per node:
  - `[p]` holds the value.
  - `[p+1]` holds the next pointer.
  - Node k of a run sits at `base + 2k`.
- State machine (Moore; outputs decoded from the state register):
  - **IDLE:**
    - If `start=1` and `base` is not 0 and not all-ones: `ptr<=base`, `count<=0`, `err<=0`, go to ACCEPT.
    - If `start=1` with an illegal `base`: `err<=1`, go to DONE; no writes are issued.
  - **ACCEPT:** `in_ready=1`. On handshake, latch `in_data` and `in_last`, then go to WR_VAL. Otherwise stay.
  - **WR_VAL:** `mem_we=1`, `mem_addr=ptr`, `mem_wdata=data`. Go to WR_NEXT.
  - **WR_NEXT:** `mem_we=1`, `mem_addr=ptr+1`. Also `count<=count+1` and `ptr<=ptr+2`.
    - If last: write `wdata=0`, go to DONE.
    - If not last and `ptr+2` (computed at AW+1 bits) exceeds `2^AW-2`: write `wdata=0`, `err<=1`, go to DONE. No further elements are accepted; the list in memory stays terminated.
    - Otherwise: write `wdata=ptr+2`, go to ACCEPT.
  - **DONE:** `done=1`. Stay while `start=1`; go to IDLE when `start=0`.
- `start` is ignored in ACCEPT, WR_VAL and WR_NEXT.
- `count` and `err` hold their values through DONE and IDLE until the next accepted start.
- `in_ready` is 0 in every state except ACCEPT. `mem_we` is 0 in every state except WR_VAL and WR_NEXT.

## Timing
- Reset values: state IDLE; `ptr=0`, `count=0`, `err=0`, `done=0`, `in_ready=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`.
- Reset asserted mid-run: return to IDLE immediately and asynchronously; `mem_we` drops at once. Memory contents written so far are undefined as a list.
- Start to first `in_ready`: 1 cycle.
- Each element costs 3 cycles minimum: accept, value write, pointer write. Peak throughput is 1 element per 3 cycles.
- Final pointer write to `done=1`: 1 cycle.
- Illegal `base` to `done=1`: 1 cycle.
- `in_valid` may drop while `in_ready=1` without penalty. Data is latched only on the handshake edge.

## Structure
- Shared package `list_pkg`:
  - state encoding: IDLE, ACCEPT, WR_VAL, WR_NEXT, DONE.
  - `VAL_OFS=0`, `NEXT_OFS=1`, `NODE_WORDS=2`, `NULL_PTR=0`.
  - The summation controller imports the same node constants.
- One sub-module, `list_builder_fsm`: state register plus next-state and output decode.
- The top level holds the datapath: `ptr`, `count`, data/last latches, and the address/wdata muxes.

## Test plan
- **Three-element list:** `base=0x10`, elements 5, 7, 9 (`last` on 9).
  - Required writes: 10←5, 11←0x12, 12←7, 13←0x14, 14←9, 15←0.
  - Then `done=1`, `count=3`, `err=0`.
- **Illegal base:** `start` with `base=0x00`, then again with `base=0xFF`. Each gives `done=1`, `err=1` after 1 cycle, with zero `mem_we` pulses.
- **Overflow, AW=8:** `base=0xFA`, five non-last elements.
  - Nodes are written at FA, FC and FE; FF←0; `err=1`, `count=3`.
  - The 4th element is never handshaken.
- **Backpressure:** 2-cycle gaps on `in_valid`. Written contents are identical to the first test; `in_ready` is high only in ACCEPT; no writes occur while waiting.
- **Handshake:** hold `start=1` after done. The block stays in DONE and does not restart. Drop `start`; IDLE is reached the next cycle, and re-raising `start` begins a new run with `count` cleared.
- **Reset mid-run:** assert `rst` low during WR_VAL. `mem_we` goes to 0 asynchronously; after release all outputs are at their reset values.
